// File: rtl/inv_nibble_sub_word.sv
// Iterative inverse nibble substitution for the simplified-AES decrypt path.
// One nibble per clock, LSB nibble first, with valid/ready on both sides.
module inv_nibble_sub_word #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 busy
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_work;
    logic [W-1:0]    w_work_next;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_out_data;
    logic            w_last;

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hE;
            4'h1: r = 4'h3;
            4'h2: r = 4'h4;
            4'h3: r = 4'h8;
            4'h4: r = 4'h1;
            4'h5: r = 4'hC;
            4'h6: r = 4'hA;
            4'h7: r = 4'hF;
            4'h8: r = 4'h7;
            4'h9: r = 4'hD;
            4'hA: r = 4'h9;
            4'hB: r = 4'h6;
            4'hC: r = 4'hB;
            4'hD: r = 4'h2;
            4'hE: r = 4'h0;
            default: r = 4'h5;
        endcase
        return r;
    endfunction

    // Decode-per-nibble rather than a variable part-select keeps every index in range.
    always_comb begin
        w_work_next = r_work;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_work_next[4*i +: 4] = inv_sbox(r_work[4*i +: 4]);
            end
        end
    end

    assign w_last = (r_idx == IDXW'(NIBBLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_SUB;
            ST_SUB:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_idx  <= '0;
                    end
                end
                ST_SUB: begin
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_out_data <= w_work_next;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_inv_nibble_sub_word.sv
// Directed bench for inv_nibble_sub_word: 4-nibble instance plus a 1-nibble instance.
module tb_inv_nibble_sub_word;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    logic        in_valid_1;
    logic        in_ready_1;
    logic [3:0]  in_data_1;
    logic        out_valid_1;
    logic        out_ready_1;
    logic [3:0]  out_data_1;
    logic        busy_1;

    int n_checks;
    int n_fail;

    logic [3:0] fwd_tab [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};
    logic [3:0] inv_tab [16] = '{4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
                                 4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5};

    inv_nibble_sub_word #(.NIBBLES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    inv_nibble_sub_word #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .in_data   (in_data_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .out_data  (out_data_1),
        .busy      (busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fwd_word(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = fwd_tab[w[4*i +: 4]];
        return r;
    endfunction

    // One transaction with out_ready high; lat counts negedges from the accept edge to out_valid.
    task automatic run_word(input logic [15:0] din, output logic [15:0] dout,
                            output int lat, output int busy_cnt, output logic rdy_after);
        int t;
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            busy_cnt += busy ? 1 : 0;
        end
        dout = out_data;
        @(negedge clk);
        busy_cnt += busy ? 1 : 0;
        rdy_after = in_ready;
    endtask

    initial begin
        logic [15:0] dout;
        logic [15:0] w;
        int          lat;
        int          bcnt;
        int          n;
        logic        rdy;
        logic        seen;

        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        in_valid_1  = 1'b0;
        in_data_1   = '0;
        out_ready_1 = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        rst_n = 1'b1;

        // Basic latency and result
        run_word(16'h1234, dout, lat, bcnt, rdy);
        check("w1234_data", {16'd0, dout}, 32'h3481);
        check("w1234_lat", lat, 5);
        check("w1234_rdy_after", {31'd0, rdy}, 32'd1);
        check("w1234_busy_cnt", bcnt, 5);

        // Asynchronous reset mid-SUB
        @(negedge clk);
        in_data  = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {16'd0, out_data}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("midrst_no_result", {31'd0, seen}, 32'd0);

        // Back-to-back with in_valid held high
        @(negedge clk);
        in_data  = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'hFEDC;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_data", {16'd0, out_data}, 32'hEEEE);
        check("b2b_first_lat", n, 5);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_accept_gap", n, 6);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_data", {16'd0, out_data}, 32'h502B);
        check("b2b_second_lat", n, 5);
        @(negedge clk);

        // Back-pressure: hold DONE for 10 cycles while in_valid pulses
        out_ready = 1'b0;
        @(negedge clk);
        in_data  = 16'hE4D1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", n, 5);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 16'hAAAA;
            @(negedge clk);
            if (!out_valid || out_data !== 16'h0123 || in_ready) seen = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_hold_stable", {31'd0, seen}, 32'd0);
        check("bp_data", {16'd0, out_data}, 32'h0123);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("bp_no_extra_accept", {31'd0, busy}, 32'd0);

        // Round trip through the forward map on a sample of words
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) w = 16'h0000;
            else if (i == 1) w = 16'hFFFF;
            else w = 16'($urandom);
            run_word(fwd_word(w), dout, lat, bcnt, rdy);
            check("rt_data", {16'd0, dout}, {16'd0, w});
            if (bcnt != 5 || lat != 5) seen = 1'b1;
        end
        check("rt_busy_lat", {31'd0, seen}, 32'd0);

        // Single-nibble instance
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            in_data_1  = 4'(v);
            in_valid_1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid_1 = 1'b0;
            n = 1;
            while (!out_valid_1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("n1_data", {28'd0, out_data_1}, {28'd0, inv_tab[v]});
            check("n1_lat", n, 2);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
